// File: rtl/proj_unidade_controle.sv
// ============================================================================
// proj_unidade_controle: Moore control unit sequencing the chess-move game datapath
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module proj_unidade_controle #(
  parameter int BONUS = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fimT,
  input  logic       acertou,
  input  logic       temJogada,
  output logic       zeraT,
  output logic       zeraR,
  output logic       zeraP,
  output logic       zeraG,
  output logic       novaJogada,
  output logic       registraR,
  output logic       contaT,
  output logic       decresceT,
  output logic       contaP,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int CW = (BONUS > 0) ? $clog2(BONUS + 1) : 1;
  localparam int BL = (BONUS > 0) ? BONUS - 1 : 0;
  localparam logic [CW-1:0] BONUS_LAST = CW'(BL);

  typedef enum logic [3:0] {
    ST_INICIAL  = 4'h0,
    ST_PREPARA  = 4'h1,
    ST_GERA     = 4'h2,
    ST_ESPERA   = 4'h3,
    ST_REGISTRA = 4'h4,
    ST_COMPARA  = 4'h5,
    ST_ACERTO   = 4'h6,
    ST_BONUS    = 4'h7,
    ST_ERRO     = 4'h8,
    ST_FIM      = 4'hF
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // {zeraT, zeraR, zeraP, zeraG, novaJogada, registraR, contaT, decresceT, contaP, pronto}
  logic [9:0]    out_q, out_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INICIAL:  if (iniciar) state_d = ST_PREPARA;
      ST_PREPARA:  state_d = ST_GERA;
      ST_GERA:     state_d = ST_ESPERA;
      ST_ESPERA: begin
        if (fimT)           state_d = ST_FIM;
        else if (temJogada) state_d = ST_REGISTRA;
      end
      ST_REGISTRA: state_d = fimT ? ST_FIM : ST_COMPARA;
      ST_COMPARA: begin
        if (fimT)         state_d = ST_FIM;
        else if (acertou) state_d = ST_ACERTO;
        else              state_d = ST_ERRO;
      end
      ST_ACERTO: begin
        cnt_d   = '0;
        state_d = (BONUS > 0) ? ST_BONUS : ST_GERA;
      end
      ST_BONUS: begin
        // Counter holds the number of bonus cycles already spent in this visit
        if (cnt_q == BONUS_LAST) begin
          cnt_d   = '0;
          state_d = ST_GERA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ERRO:     state_d = ST_ESPERA;
      ST_FIM:      if (iniciar) state_d = ST_PREPARA;
      default:     state_d = ST_INICIAL;
    endcase

    // Outputs are decoded from the next state so they register alongside it
    out_d = '0;
    case (state_d)
      ST_PREPARA:  out_d = 10'b1111_000000;
      ST_GERA:     out_d = 10'b0000_100000;
      ST_ESPERA:   out_d = 10'b0000_001000;
      ST_REGISTRA: out_d = 10'b0000_011000;
      ST_COMPARA:  out_d = 10'b0000_001000;
      ST_ACERTO:   out_d = 10'b0000_000010;
      ST_BONUS:    out_d = 10'b0000_000100;
      ST_ERRO:     out_d = 10'b0100_000000;
      ST_FIM:      out_d = 10'b0000_000001;
      default:     out_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INICIAL;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign zeraT      = out_q[9];
  assign zeraR      = out_q[8];
  assign zeraP      = out_q[7];
  assign zeraG      = out_q[6];
  assign novaJogada = out_q[5];
  assign registraR  = out_q[4];
  assign contaT     = out_q[3];
  assign decresceT  = out_q[2];
  assign contaP     = out_q[1];
  assign pronto     = out_q[0];
  assign db_estado  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_proj_unidade_controle.sv
// ============================================================================
// tb_proj_unidade_controle: scoreboard bench for BONUS=4 and BONUS=0 instances
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proj_unidade_controle;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, fimT = 1'b0, acertou = 1'b0, temJogada = 1'b0;

  logic       zT4, zR4, zP4, zG4, nJ4, rR4, cT4, dT4, cP4, pr4;
  logic [3:0] db4;
  logic       zT0, zR0, zP0, zG0, nJ0, rR0, cT0, dT0, cP0, pr0;
  logic [3:0] db0;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  always #5 clock = ~clock;

  proj_unidade_controle #(.BONUS(4)) dut4 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimT(fimT),
    .acertou(acertou), .temJogada(temJogada),
    .zeraT(zT4), .zeraR(zR4), .zeraP(zP4), .zeraG(zG4), .novaJogada(nJ4),
    .registraR(rR4), .contaT(cT4), .decresceT(dT4), .contaP(cP4),
    .pronto(pr4), .db_estado(db4)
  );

  proj_unidade_controle #(.BONUS(0)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimT(fimT),
    .acertou(acertou), .temJogada(temJogada),
    .zeraT(zT0), .zeraR(zR0), .zeraP(zP0), .zeraG(zG0), .novaJogada(nJ0),
    .registraR(rR0), .contaT(cT0), .decresceT(dT0), .contaP(cP0),
    .pronto(pr0), .db_estado(db0)
  );

  wire [13:0] act4 = {db4, zT4, zR4, zP4, zG4, nJ4, rR4, cT4, dT4, cP4, pr4};
  wire [13:0] act0 = {db0, zT0, zR0, zP0, zG0, nJ0, rR0, cT0, dT0, cP0, pr0};

  // Expected output table per state code, written from the state/output list
  function automatic logic [13:0] exp_vec(input logic [3:0] s);
    logic [9:0] o;
    case (s)
      4'h1:    o = 10'b1111_000000;
      4'h2:    o = 10'b0000_100000;
      4'h3:    o = 10'b0000_001000;
      4'h4:    o = 10'b0000_011000;
      4'h5:    o = 10'b0000_001000;
      4'h6:    o = 10'b0000_000010;
      4'h7:    o = 10'b0000_000100;
      4'h8:    o = 10'b0100_000000;
      4'hF:    o = 10'b0000_000001;
      default: o = 10'b0;
    endcase
    return {s, o};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: after each rising edge, pop one expected pair and compare both instances
  always @(posedge clock) begin
    logic [7:0] e;
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("b4_cycle", act4, exp_vec(e[7:4]));
      check("b0_cycle", act0, exp_vec(e[3:0]));
    end
  end

  task automatic cyc(input logic ini, input logic fim, input logic ac, input logic tj,
                     input logic [3:0] e4, input logic [3:0] e0);
    @(negedge clock);
    iniciar = ini; fimT = fim; acertou = ac; temJogada = tj;
    @(posedge clock);
    sb_q.push_back({e4, e0});
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 4'h0, 4'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held from time 0
    #3;
    check("rst_b4", act4, 14'h0);
    check("rst_b0", act0, 14'h0);
    release_reset();

    // Start
    cyc(1, 0, 0, 0, 4'h1, 4'h1);
    cyc(0, 0, 0, 0, 4'h2, 4'h2);
    cyc(0, 0, 0, 0, 4'h3, 4'h3);
    cyc(0, 0, 0, 0, 4'h3, 4'h3);

    // Hit: BONUS=4 spends four cycles in 0x7, BONUS=0 goes straight to GERA
    cyc(0, 0, 1, 1, 4'h4, 4'h4);
    cyc(0, 0, 1, 0, 4'h5, 4'h5);
    cyc(0, 0, 1, 0, 4'h6, 4'h6);
    cyc(0, 0, 0, 0, 4'h7, 4'h2);
    cyc(0, 0, 0, 0, 4'h7, 4'h3);
    cyc(0, 0, 0, 0, 4'h7, 4'h3);
    cyc(0, 0, 0, 0, 4'h7, 4'h3);
    cyc(0, 0, 0, 0, 4'h2, 4'h3);
    cyc(0, 0, 0, 0, 4'h3, 4'h3);

    // Miss, with a stray temJogada in REGISTRA that must be dropped
    cyc(0, 0, 0, 1, 4'h4, 4'h4);
    cyc(0, 0, 0, 1, 4'h5, 4'h5);
    cyc(0, 0, 0, 0, 4'h8, 4'h8);
    cyc(0, 0, 0, 0, 4'h3, 4'h3);
    cyc(0, 0, 0, 0, 4'h3, 4'h3);

    // fimT together with acertou in COMPARA -> FIM without scoring
    cyc(0, 0, 1, 1, 4'h4, 4'h4);
    cyc(0, 0, 1, 0, 4'h5, 4'h5);
    cyc(0, 1, 1, 0, 4'hF, 4'hF);
    cyc(0, 0, 0, 0, 4'hF, 4'hF);
    cyc(0, 0, 0, 0, 4'hF, 4'hF);

    // Restart; fimT is ignored in PREPARA and GERA, caught in ESPERA over temJogada
    cyc(1, 0, 0, 0, 4'h1, 4'h1);
    cyc(0, 1, 0, 0, 4'h2, 4'h2);
    cyc(0, 1, 0, 0, 4'h3, 4'h3);
    cyc(0, 1, 0, 1, 4'hF, 4'hF);
    cyc(0, 0, 0, 0, 4'hF, 4'hF);

    // Restart, then asynchronous reset while in COMPARA
    cyc(1, 0, 0, 0, 4'h1, 4'h1);
    cyc(0, 0, 0, 0, 4'h2, 4'h2);
    cyc(0, 0, 0, 0, 4'h3, 4'h3);
    cyc(0, 0, 0, 1, 4'h4, 4'h4);
    cyc(0, 0, 0, 0, 4'h5, 4'h5);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_b4", act4, 14'h0);
    check("async_rst_b0", act0, 14'h0);
    release_reset();

    repeat (3) @(posedge clock);
    #4;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
